// File: rtl/aeolus_multicycle_core.sv
`timescale 1ns/1ps
// Aeolus multi-cycle core: FETCH/DECODE/EXECUTE/HALT sequencer around an A/B/O
// register file and a double-width accumulator, fed by an external 1-cycle ROM.
module aeolus_multicycle_core #(
  parameter int DATA_WIDTH = 4,
  parameter int PC_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic [2*DATA_WIDTH-1:0] switches,
  output logic [PC_WIDTH-1:0]     imem_addr,
  input  logic [7:0]              imem_data,
  output logic [2*DATA_WIDTH-1:0] cpu_out,
  output logic                    out_valid,
  output logic                    carry,
  output logic                    zero,
  output logic                    halted
);

  localparam int W  = DATA_WIDTH;
  localparam int AW = 2 * DATA_WIDTH;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_LDB = 4'h2;
  localparam logic [3:0] OP_LDO = 4'h3;
  localparam logic [3:0] OP_CLR = 4'h4;
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_AND = 4'h7;
  localparam logic [3:0] OP_OR  = 4'h8;
  localparam logic [3:0] OP_XOR = 4'h9;
  localparam logic [3:0] OP_INV = 4'hA;
  localparam logic [3:0] OP_LSH = 4'hB;
  localparam logic [3:0] OP_RSH = 4'hC;
  localparam logic [3:0] OP_SNZ = 4'hD;
  localparam logic [3:0] OP_JMP = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, HALT} state_t;

  state_t                state, state_nxt;
  logic [PC_WIDTH-1:0]   pc, pc_nxt;
  logic [7:0]            ir;
  logic [W-1:0]          a, b;
  logic [AW-1:0]         acc, o;
  logic [3:0]            opcode;
  logic [3:0]            imm;

  // Returns {carry, acc}; opcodes outside the ALU group leave both untouched.
  function automatic logic [AW:0] alu(input logic [3:0] op, input logic [W-1:0] a_v,
                                      input logic [W-1:0] b_v, input logic [AW-1:0] acc_v,
                                      input logic c_v);
    logic [AW-1:0] ax, bx, s;
    ax  = {{W{1'b0}}, a_v};
    bx  = {{W{1'b0}}, b_v};
    s   = ax + bx;
    alu = {c_v, acc_v};
    case (op)
      OP_CLR:  alu = {c_v, {AW{1'b0}}};
      OP_ADD:  alu = {s[W], s};
      OP_SUB:  alu = {(a_v < b_v), ax - bx};
      OP_AND:  alu = {c_v, ax & bx};
      OP_OR:   alu = {c_v, ax | bx};
      OP_XOR:  alu = {c_v, ax ^ bx};
      OP_INV:  alu = {c_v, {W{1'b0}}, ~a_v};
      OP_LSH:  alu = {acc_v, 1'b0};
      OP_RSH:  alu = {acc_v[0], 1'b0, acc_v[AW-1:1]};
      default: ;
    endcase
    return alu;
  endfunction

  assign opcode    = ir[7:4];
  assign imm       = ir[3:0];
  assign imem_addr = pc;
  assign cpu_out   = o;
  assign zero      = (acc == '0);
  assign halted    = (state == HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (run) state_nxt = DECODE;
      DECODE:  state_nxt = EXECUTE;
      EXECUTE: state_nxt = (opcode == OP_HLT) ? HALT : FETCH;
      default: state_nxt = HALT;
    endcase
  end

  always_comb begin
    pc_nxt = pc + PC_WIDTH'(1);
    case (opcode)
      OP_SNZ:  if (acc != '0) pc_nxt = pc + PC_WIDTH'(2);
      OP_JMP:  pc_nxt = PC_WIDTH'(imm);
      OP_HLT:  pc_nxt = pc;
      default: ;
    endcase
  end

  // ---- datapath: IR loads on DECODE, architectural state updates on EXECUTE ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= '0;
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      acc       <= '0;
      o         <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        DECODE: ir <= imem_data;
        EXECUTE: begin
          pc           <= pc_nxt;
          {carry, acc} <= alu(opcode, a, b, acc, carry);
          case (opcode)
            OP_LDA: a <= switches[AW-1:W];
            OP_LDB: b <= switches[W-1:0];
            OP_LDO: begin
              o         <= acc;
              out_valid <= 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
